piso_stream: RTL and testbench
==============================

# piso_stream

Parametrised parallel-in/serial-out shifter with a load/ready handshake, selectable bit order, shift-enable pacing and back-to-back word streaming. It replaces the fixed 4-bit PISO. A producer hands it WIDTH-bit words. It serialises each word onto `q` with a per-bit valid flag and a last-bit marker, and can take the next word on the final bit so the output stream has no gap.

## Interface
- `WIDTH`, 4: word width in bits. Legal range is 2..32.
- `MSB_FIRST`, 1: 1 sends `d_in[WIDTH-1]` first; 0 sends `d_in[0]` first.
- `IDLE_LEVEL`, 0: value driven on `q` when no bit is being presented.

- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `load`, input, 1: word-offer strobe. A word is accepted on an edge where `load && ready`.
- `d_in`, input, WIDTH: parallel word. It is sampled only on acceptance.
- `en`, input, 1: shift enable. The bit on `q` advances only on an edge where `en` is 1.
- `ready`, output, 1: block can accept a word this cycle. Combinational.
- `q`, output, 1: serial data. Registered.
- `q_valid`, output, 1: `q` carries a word bit. Registered.
- `last`, output, 1: `q` carries the final bit of the word. Registered.
- `busy`, output, 1: a word is being serialised. Equals `q_valid`.

## Operation
- State is held in a WIDTH-bit shift register `sr`, a bit counter `cnt` of width clog2(WIDTH), and a 2-state FSM: IDLE and SHIFT.
- **`ready`:** `ready = !rst && (state==IDLE || (last && en))`.
- **IDLE:**
  - `q`=IDLE_LEVEL, `q_valid`=0, `last`=0.
  - On `load && ready`: `sr` ← `d_in`, `cnt` ← 0, go to SHIFT.
  - `q` takes the first bit: `d_in[WIDTH-1]` if MSB_FIRST, else `d_in[0]`.
- **SHIFT, `en`=0:**
  - All state holds. `q`, `q_valid`, `last` are unchanged.
  - `load` is ignored unless `ready` is high, which requires `en`.
- **SHIFT, `en`=1, `cnt` < WIDTH-1:**
  - `sr` shifts toward the output end: left if MSB_FIRST, right otherwise, with zero fill.
  - `cnt` ← `cnt`+1 and `q` ← next bit.
  - `last` ← 1 when the new `cnt` equals WIDTH-1.
- **SHIFT, `en`=1, `cnt`==WIDTH-1 (final bit):**
  - With `load`=1: the new word loads exactly as from IDLE and the state stays SHIFT. This gives back-to-back streaming with no IDLE_LEVEL bubble.
  - With `load`=0: go to IDLE, and `q` returns to IDLE_LEVEL with `q_valid`=0 and `last`=0.
- **`d_in` sampling:** `d_in` changes while not accepted have no effect on the word in flight.
- **Reset:**
  - `rst` overrides everything, including mid-word. The word in flight is discarded, not completed.
  - `load` is ignored while `rst`=1.
  - Reset values: state=IDLE, `sr`=0, `cnt`=0, `q`=IDLE_LEVEL, `q_valid`=0, `last`=0, `busy`=0, `ready`=0.
- **WIDTH=2:** `last` asserts on the second bit. No degenerate case is permitted below WIDTH=2.

## Timing
- **Load latency:** acceptance at edge k puts the first bit on `q` with `q_valid`=1 after edge k.
- **Bit rate:** with `en` held at 1, bit i appears after edge k+i. `last` is high after edge k+WIDTH-1, for one `en` cycle.
- **Word period:** WIDTH `en`-qualified cycles. Continuous streaming with `load` held high is one bit per clock and never drops `q_valid`.
- **Stall:** `en`=0 stretches the current bit by one clock per stalled cycle. No bits are lost or duplicated.
- **Release:** `rst` deasserting at edge r allows acceptance at edge r+1 at the earliest.

## Test plan
- **MSB-first word:** WIDTH=4, MSB_FIRST=1, `en`=1, `d_in`=4'b1101, one-cycle `load` after reset.
  - `q` = 1,1,0,1 on the next four cycles with `q_valid`=1.
  - `last` high on the 4th bit only, then `q`=0 and `q_valid`=0.
- **LSB-first and idle level:** same stimulus with MSB_FIRST=0, IDLE_LEVEL=1.
  - `q` = 1,0,1,1.
  - `q`=1 and `q_valid`=0 before and after the word.
- **Back-to-back:** `load` held high with `d_in`=4'b1101, then 4'b0010 presented at the `last` cycle.
  - `q` = 1,1,0,1,0,0,1,0 contiguous, `q_valid` never drops.
  - `ready` high only in IDLE and on `last` cycles.
- **Stall:** `en`=0 for 3 clocks during the 2nd bit of 4'b1101.
  - The 2nd bit is held 4 clocks total, then the remaining bits 0,1 follow.
  - `ready`=0 throughout the stall.
- **Reset mid-word:** assert `rst` on the 3rd bit.
  - Next cycle `q`=IDLE_LEVEL, `q_valid`=0, `last`=0, `ready`=0.
  - After release, a new word 4'b1010 serialises as 1,0,1,0.
- **Width sweep:** WIDTH=2 and WIDTH=32 with random words and random `en`.
  - A scoreboard reassembles each word and matches it to `d_in` at acceptance.
  - Exactly one `last` per word.

Source files
------------

// File: rtl/piso_stream_if.sv
// Word-in / bit-out bundle between a word producer and piso_stream.
// Latency: none; plain wires.
// Backpressure: producer holds load/d_in until it sees ready at a clock edge.
// Ports: load, d_in, en (producer -> shifter); ready, q, q_valid, last, busy (shifter -> producer/consumer).
interface piso_stream_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             en;
  logic             ready;
  logic             q;
  logic             q_valid;
  logic             last;
  logic             busy;

  modport master (
    output load, d_in, en,
    input  ready, q, q_valid, last, busy
  );

  modport slave (
    input  load, d_in, en,
    output ready, q, q_valid, last, busy
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter: WIDTH-bit words out on q, one bit per en cycle, with last marker.
// Latency: first bit on q one clock after acceptance (load && ready); q/q_valid/last are registered.
// Backpressure: ready is high only in IDLE or on an en-qualified last bit; en=0 stalls the current bit.
// Ports: clk, rst (sync, active-high); bus = piso_stream_if slave (load/d_in/en in, ready/q/q_valid/last/busy out).
module piso_stream #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic           clk,
  input logic           rst,
  piso_stream_if.slave  bus
);

  localparam int                 CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt, w_sr_shift;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_q, w_q_nxt;
  logic             r_q_valid, w_q_valid_nxt;
  logic             r_last, w_last_nxt;
  logic             w_ready, w_accept, w_final;

  // r_last is only ever set on the final bit, so "last && en" is exactly the
  // edge where the final bit leaves and the next word may take its place.
  assign w_ready    = !rst && ((r_state == S_IDLE) || (r_last && bus.en));
  assign w_accept   = bus.load && w_ready;
  assign w_final    = (r_cnt == CNT_MAX);
  // Shift toward the output end, zero fill; the bit presented on q is always
  // the output-end bit of the shifted register.
  assign w_sr_shift = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_q_nxt       = r_q;
    w_q_valid_nxt = r_q_valid;
    w_last_nxt    = r_last;

    if (w_accept) begin
      // Same path from IDLE and from the final bit: back-to-back with no bubble.
      w_state_nxt   = S_SHIFT;
      w_sr_nxt      = bus.d_in;
      w_cnt_nxt     = '0;
      w_q_nxt       = MSB_FIRST ? bus.d_in[WIDTH-1] : bus.d_in[0];
      w_q_valid_nxt = 1'b1;
      w_last_nxt    = 1'b0;
    end else if ((r_state == S_SHIFT) && bus.en) begin
      if (w_final) begin
        w_state_nxt   = S_IDLE;
        w_q_nxt       = IDLE_LEVEL;
        w_q_valid_nxt = 1'b0;
        w_last_nxt    = 1'b0;
      end else begin
        w_sr_nxt      = w_sr_shift;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_q_nxt       = MSB_FIRST ? w_sr_shift[WIDTH-1] : w_sr_shift[0];
        w_q_valid_nxt = 1'b1;
        w_last_nxt    = ((r_cnt + CNT_W'(1)) == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_q       <= IDLE_LEVEL;
      r_q_valid <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign bus.ready   = w_ready;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.last    = r_last;
  assign bus.busy    = r_q_valid;

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: directed MSB/LSB, back-to-back, stall, reset and random width sweeps.
// Latency: drives and samples on the falling edge, away from the active edge.
// Backpressure: acceptance is load && ready observed just before the rising edge.
module tb_piso_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  piso_stream_if #(.WIDTH(4))  if_a ();
  piso_stream_if #(.WIDTH(4))  if_b ();
  piso_stream_if #(.WIDTH(2))  if_c ();
  piso_stream_if #(.WIDTH(32)) if_d ();

  piso_stream #(.WIDTH(4),  .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  piso_stream #(.WIDTH(4),  .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  piso_stream #(.WIDTH(2),  .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  piso_stream #(.WIDTH(32), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  // Expected {last, q} per presented bit, and expected words for the sweeps.
  logic [1:0]  exp_q[$];
  logic [31:0] sb_word[$];

  task automatic idle_all();
    if_a.load = 1'b0; if_a.en = 1'b1; if_a.d_in = '0;
    if_b.load = 1'b0; if_b.en = 1'b1; if_b.d_in = '0;
    if_c.load = 1'b0; if_c.en = 1'b1; if_c.d_in = '0;
    if_d.load = 1'b0; if_d.en = 1'b1; if_d.d_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    if_a.load = 1'b1;  // must be ignored while in reset
    if_a.d_in = 4'b1111;
    repeat (3) @(negedge clk);
    checks++; if (if_a.q !== 1'b0)       begin failures++; $display("FAIL reset_a_q got=%b exp=0", if_a.q); end
    checks++; if (if_a.q_valid !== 1'b0) begin failures++; $display("FAIL reset_a_q_valid got=%b exp=0", if_a.q_valid); end
    checks++; if (if_a.last !== 1'b0)    begin failures++; $display("FAIL reset_a_last got=%b exp=0", if_a.last); end
    checks++; if (if_a.busy !== 1'b0)    begin failures++; $display("FAIL reset_a_busy got=%b exp=0", if_a.busy); end
    checks++; if (if_a.ready !== 1'b0)   begin failures++; $display("FAIL reset_a_ready got=%b exp=0", if_a.ready); end
    checks++; if (if_b.q !== 1'b1)       begin failures++; $display("FAIL reset_b_idle_level got=%b exp=1", if_b.q); end
    checks++; if (if_d.q !== 1'b1)       begin failures++; $display("FAIL reset_d_idle_level got=%b exp=1", if_d.q); end
    if_a.load = 1'b0;
    if_a.d_in = '0;
    rst = 1'b0;
    #1;
    checks++; if (if_a.ready !== 1'b1)   begin failures++; $display("FAIL release_a_ready got=%b exp=1", if_a.ready); end
  endtask

  task automatic test_msb_first();
    logic [3:0] w;
    logic [1:0] e;
    w = 4'b1101;
    @(negedge clk);
    if_a.d_in = w; if_a.load = 1'b1; if_a.en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), w[3-i]});
    @(negedge clk);
    if_a.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({if_a.q_valid, if_a.last, if_a.q} !== {1'b1, e}) begin
        failures++; $display("FAIL msb_bit%0d got v/l/q=%b exp=%b", i, {if_a.q_valid, if_a.last, if_a.q}, {1'b1, e});
      end
      @(negedge clk);
    end
    checks++;
    if ({if_a.q_valid, if_a.last, if_a.q} !== 3'b000) begin
      failures++; $display("FAIL msb_after got v/l/q=%b exp=000", {if_a.q_valid, if_a.last, if_a.q});
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] w;
    logic [1:0] e;
    w = 4'b1101;
    @(negedge clk);
    checks++;
    if ({if_b.q_valid, if_b.q} !== 2'b01) begin
      failures++; $display("FAIL lsb_before got v/q=%b exp=01", {if_b.q_valid, if_b.q});
    end
    if_b.d_in = w; if_b.load = 1'b1; if_b.en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), w[i]});
    @(negedge clk);
    if_b.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({if_b.q_valid, if_b.last, if_b.q} !== {1'b1, e}) begin
        failures++; $display("FAIL lsb_bit%0d got v/l/q=%b exp=%b", i, {if_b.q_valid, if_b.last, if_b.q}, {1'b1, e});
      end
      @(negedge clk);
    end
    checks++;
    if ({if_b.q_valid, if_b.last, if_b.q} !== 3'b001) begin
      failures++; $display("FAIL lsb_after got v/l/q=%b exp=001", {if_b.q_valid, if_b.last, if_b.q});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [2];
    logic [1:0] e;
    words[0] = 4'b1101;
    words[1] = 4'b0010;
    @(negedge clk);
    checks++; if (if_a.ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready got=%b exp=1", if_a.ready); end
    if_a.d_in = words[0]; if_a.load = 1'b1; if_a.en = 1'b1;
    for (int wi = 0; wi < 2; wi++)
      for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), words[wi][3-i]});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({if_a.q_valid, if_a.last, if_a.q} !== {1'b1, e}) begin
        failures++; $display("FAIL b2b_bit%0d got v/l/q=%b exp=%b", i, {if_a.q_valid, if_a.last, if_a.q}, {1'b1, e});
      end
      checks++;
      if (if_a.ready !== ((i % 4) == 3)) begin
        failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, if_a.ready, ((i % 4) == 3));
      end
      if (i == 3) if_a.d_in = words[1];
      if (i == 7) if_a.load = 1'b0;
    end
    @(negedge clk);
    checks++; if (if_a.q_valid !== 1'b0) begin failures++; $display("FAIL b2b_after_valid got=%b exp=0", if_a.q_valid); end
  endtask

  task automatic test_stall();
    logic [3:0] w;
    logic [1:0] e;
    w = 4'b1101;
    @(negedge clk);
    if_a.d_in = w; if_a.load = 1'b1; if_a.en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), w[3-i]});
    @(negedge clk);
    if_a.load = 1'b0;
    if_a.d_in = 4'b0000;  // changes while not accepted must not matter
    e = exp_q.pop_front();
    checks++;
    if ({if_a.q_valid, if_a.last, if_a.q} !== {1'b1, e}) begin
      failures++; $display("FAIL stall_bit0 got v/l/q=%b exp=%b", {if_a.q_valid, if_a.last, if_a.q}, {1'b1, e});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    if_a.en = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({if_a.q_valid, if_a.last, if_a.q} !== {1'b1, e}) begin
        failures++; $display("FAIL stall_hold%0d got v/l/q=%b exp=%b", s, {if_a.q_valid, if_a.last, if_a.q}, {1'b1, e});
      end
      checks++; if (if_a.ready !== 1'b0) begin failures++; $display("FAIL stall_ready%0d got=%b exp=0", s, if_a.ready); end
      if (s < 3) begin
        @(negedge clk);
        if_a.d_in = 4'($urandom);
        #1;
      end
    end
    if_a.en = 1'b1;
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({if_a.q_valid, if_a.last, if_a.q} !== {1'b1, e}) begin
        failures++; $display("FAIL stall_bit%0d got v/l/q=%b exp=%b", i, {if_a.q_valid, if_a.last, if_a.q}, {1'b1, e});
      end
    end
    @(negedge clk);
    checks++; if (if_a.q_valid !== 1'b0) begin failures++; $display("FAIL stall_after_valid got=%b exp=0", if_a.q_valid); end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] w;
    logic [1:0] e;
    @(negedge clk);
    if_a.d_in = 4'b1101; if_a.load = 1'b1; if_a.en = 1'b1;
    @(negedge clk);
    if_a.load = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if_a.q !== 1'b0) begin failures++; $display("FAIL rstmid_bit2 got=%b exp=0", if_a.q); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_a.q_valid, if_a.last, if_a.q, if_a.ready, if_a.busy} !== 5'b00000) begin
      failures++; $display("FAIL rstmid_cleared got v/l/q/rdy/busy=%b exp=00000",
                           {if_a.q_valid, if_a.last, if_a.q, if_a.ready, if_a.busy});
    end
    rst = 1'b0;
    exp_q.delete();
    w = 4'b1010;
    if_a.d_in = w; if_a.load = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), w[3-i]});
    @(negedge clk);
    if_a.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({if_a.q_valid, if_a.last, if_a.q} !== {1'b1, e}) begin
        failures++; $display("FAIL rstmid_new_bit%0d got v/l/q=%b exp=%b", i, {if_a.q_valid, if_a.last, if_a.q}, {1'b1, e});
      end
      @(negedge clk);
    end
    checks++; if (if_a.q_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after_valid got=%b exp=0", if_a.q_valid); end
  endtask

  // WIDTH=2, MSB first: reassemble every consumed bit into a word.
  task automatic test_sweep_w2();
    logic [31:0] asm_w;
    logic [31:0] ew;
    int nbits;
    nbits = 0;
    asm_w = '0;
    sb_word.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc < 370) begin
        if_c.en   = ($urandom_range(0, 3) != 0);
        if_c.load = ($urandom_range(0, 2) != 0);
        if_c.d_in = 2'($urandom);
      end else begin
        if_c.en = 1'b1; if_c.load = 1'b0;
      end
      #1;
      if (if_c.q_valid && if_c.en) begin
        asm_w[1-nbits] = if_c.q;
        checks++;
        if (if_c.last !== (nbits == 1)) begin
          failures++; $display("FAIL w2_last cyc=%0d bit=%0d got=%b exp=%b", cyc, nbits, if_c.last, (nbits == 1));
        end
        nbits++;
        if (nbits == 2) begin
          checks++;
          if (sb_word.size() == 0) begin
            failures++; $display("FAIL w2_word cyc=%0d got=%h exp=<none queued>", cyc, asm_w[1:0]);
          end else begin
            ew = sb_word.pop_front();
            if (asm_w[1:0] !== ew[1:0]) begin
              failures++; $display("FAIL w2_word cyc=%0d got=%h exp=%h", cyc, asm_w[1:0], ew[1:0]);
            end
          end
          nbits = 0;
        end
      end
      if (if_c.load && if_c.ready) sb_word.push_back(32'(if_c.d_in));
    end
    checks++;
    if (sb_word.size() != 0 || nbits != 0 || if_c.q_valid !== 1'b0) begin
      failures++; $display("FAIL w2_drain got pending=%0d partial=%0d valid=%b exp=0/0/0", sb_word.size(), nbits, if_c.q_valid);
    end
  endtask

  // WIDTH=32, LSB first.
  task automatic test_sweep_w32();
    logic [31:0] asm_w;
    logic [31:0] ew;
    int nbits;
    nbits = 0;
    asm_w = '0;
    sb_word.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (cyc < 720) begin
        if_d.en   = ($urandom_range(0, 3) != 0);
        if_d.load = ($urandom_range(0, 1) != 0);
        if_d.d_in = $urandom;
      end else begin
        if_d.en = 1'b1; if_d.load = 1'b0;
      end
      #1;
      if (if_d.q_valid && if_d.en) begin
        asm_w[nbits] = if_d.q;
        checks++;
        if (if_d.last !== (nbits == 31)) begin
          failures++; $display("FAIL w32_last cyc=%0d bit=%0d got=%b exp=%b", cyc, nbits, if_d.last, (nbits == 31));
        end
        nbits++;
        if (nbits == 32) begin
          checks++;
          if (sb_word.size() == 0) begin
            failures++; $display("FAIL w32_word cyc=%0d got=%h exp=<none queued>", cyc, asm_w);
          end else begin
            ew = sb_word.pop_front();
            if (asm_w !== ew) begin
              failures++; $display("FAIL w32_word cyc=%0d got=%h exp=%h", cyc, asm_w, ew);
            end
          end
          nbits = 0;
        end
      end
      if (if_d.load && if_d.ready) sb_word.push_back(if_d.d_in);
    end
    checks++;
    if (sb_word.size() != 0 || nbits != 0 || if_d.q_valid !== 1'b0 || if_d.q !== 1'b1) begin
      failures++; $display("FAIL w32_drain got pending=%0d partial=%0d valid=%b q=%b exp=0/0/0/1",
                           sb_word.size(), nbits, if_d.q_valid, if_d.q);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_sweep_w2();
    test_sweep_w32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
